// File: rtl/sevenseg_scan_if.sv
// Signal bundle between a hex-word producer, the 7-segment scan driver and the board pins.
// load is a one-cycle strobe with no ready: the driver accepts every load, the last one before a frame boundary wins.
interface sevenseg_scan_if #(
   parameter int DIGITS = 4
);
   logic                  enable;
   logic                  load;
   logic [4*DIGITS-1:0]   value;
   logic [DIGITS-1:0]     dp_in;
   logic                  lz_en;
   logic [6:0]            seg;
   logic                  dp;
   logic [DIGITS-1:0]     an;
   logic                  pending;
   logic                  frame_done;

   modport master (
      output enable, load, value, dp_in, lz_en,
      input  seg, dp, an, pending, frame_done
   );

   modport slave (
      input  enable, load, value, dp_in, lz_en,
      output seg, dp, an, pending, frame_done
   );
endinterface

// File: rtl/sevenseg_scan_driver.sv
// Time-multiplexed 7-segment driver: scans one digit per refresh slot from a shadow copy
// that only changes at frame boundaries, with anti-ghost blanking and leading-zero suppression.
module sevenseg_scan_driver #(
   parameter int DIGITS         = 4,
   parameter int REFRESH_DIV    = 1000,
   parameter int BLANK_CYCLES   = 1,
   parameter bit SEG_ACTIVE_LOW = 1'b0,
   parameter bit AN_ACTIVE_LOW  = 1'b0
) (
   input logic          clk,
   input logic          rst,
   sevenseg_scan_if.slave bus
);
   localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int SW = 5 * DIGITS;
   localparam logic [CW-1:0]     CNT_LAST  = CW'(REFRESH_DIV - 1);
   localparam logic [CW-1:0]     CNT_BLANK = CW'(BLANK_CYCLES);
   localparam logic [IW-1:0]     IDX_LAST  = IW'(DIGITS - 1);
   localparam logic [6:0]        SEG_OFF   = {7{SEG_ACTIVE_LOW}};
   localparam logic              DP_OFF    = SEG_ACTIVE_LOW;
   localparam logic [DIGITS-1:0] AN_OFF    = {DIGITS{AN_ACTIVE_LOW}};

   logic [CW-1:0]       cnt_q, cnt_d;
   logic [IW-1:0]       idx_q, idx_d;
   logic [SW-1:0]       stage_q, stage_d;
   logic [SW-1:0]       shadow_q, shadow_d;
   logic                pending_q, pending_d;
   logic                frame_done_q, frame_done_d;
   logic [6:0]          seg_q, seg_d;
   logic                dp_q, dp_d;
   logic [DIGITS-1:0]   an_q, an_d;
   logic                slot_end, boundary;
   logic [4*DIGITS-1:0] shadow_val;
   logic [DIGITS-1:0]   shadow_dp;
   logic [3:0]          nib;
   logic [6:0]          seg_lit;
   logic                lz_blank;

   function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
      case (n)
         4'h0: hex_to_seg = 7'b1111110;
         4'h1: hex_to_seg = 7'b0110000;
         4'h2: hex_to_seg = 7'b1101101;
         4'h3: hex_to_seg = 7'b1111001;
         4'h4: hex_to_seg = 7'b0110011;
         4'h5: hex_to_seg = 7'b1011011;
         4'h6: hex_to_seg = 7'b1011111;
         4'h7: hex_to_seg = 7'b1110000;
         4'h8: hex_to_seg = 7'b1111111;
         4'h9: hex_to_seg = 7'b1110011;
         4'hA: hex_to_seg = 7'b1110111;
         4'hB: hex_to_seg = 7'b0011111;
         4'hC: hex_to_seg = 7'b1001110;
         4'hD: hex_to_seg = 7'b0111101;
         4'hE: hex_to_seg = 7'b1001111;
         default: hex_to_seg = 7'b1000111;
      endcase
   endfunction

   // Scan position and staging -> shadow transfer.
   always_comb begin
      slot_end     = (cnt_q == CNT_LAST);
      boundary     = bus.enable && slot_end && (idx_q == IDX_LAST);
      cnt_d        = cnt_q;
      idx_d        = idx_q;
      stage_d      = stage_q;
      shadow_d     = shadow_q;
      pending_d    = pending_q;
      frame_done_d = boundary;
      if (bus.enable) begin
         cnt_d = slot_end ? '0 : cnt_q + 1'b1;
         if (slot_end) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end
      if (bus.load) stage_d = {bus.value, bus.dp_in};
      if (boundary) begin
         // A load landing on the boundary goes straight to the shadow so it is not held a whole frame.
         if (bus.load)      shadow_d = {bus.value, bus.dp_in};
         else if (pending_q) shadow_d = stage_q;
         pending_d = 1'b0;
      end else if (bus.load) begin
         pending_d = 1'b1;
      end
   end

   // Segment/anode values for the current slot, polarity applied last.
   always_comb begin
      shadow_val = shadow_q[SW-1:DIGITS];
      shadow_dp  = shadow_q[DIGITS-1:0];
      nib        = shadow_val[4*idx_q +: 4];
      lz_blank   = bus.lz_en && (idx_q != '0);
      for (int j = 0; j < DIGITS; j++) begin
         if ((IW'(j) >= idx_q) && (shadow_val[4*j +: 4] != 4'h0)) lz_blank = 1'b0;
      end
      seg_lit = lz_blank ? 7'b0000000 : hex_to_seg(nib);
      seg_d   = SEG_OFF;
      dp_d    = DP_OFF;
      an_d    = AN_OFF;
      if (bus.enable) begin
         seg_d = seg_lit ^ SEG_OFF;
         dp_d  = shadow_dp[idx_q] ^ DP_OFF;
         if (cnt_q >= CNT_BLANK) begin
            an_d        = '0;
            an_d[idx_q] = 1'b1;
            an_d        = an_d ^ AN_OFF;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q        <= '0;
         idx_q        <= '0;
         stage_q      <= '0;
         shadow_q     <= '0;
         pending_q    <= 1'b0;
         frame_done_q <= 1'b0;
         seg_q        <= SEG_OFF;
         dp_q         <= DP_OFF;
         an_q         <= AN_OFF;
      end else begin
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         stage_q      <= stage_d;
         shadow_q     <= shadow_d;
         pending_q    <= pending_d;
         frame_done_q <= frame_done_d;
         seg_q        <= seg_d;
         dp_q         <= dp_d;
         an_q         <= an_d;
      end
   end

   assign bus.seg        = seg_q;
   assign bus.dp         = dp_q;
   assign bus.an         = an_q;
   assign bus.pending    = pending_q;
   assign bus.frame_done = frame_done_q;
endmodule
